// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: filter geometry, weight/filter typedefs
// and the filter loader state encoding.
package cnn_pkg;

   localparam int FILTER_N = 5;
   localparam int WEIGHT_W = 16;
   localparam int WADDR_W  = 16;

   typedef logic signed [WEIGHT_W-1:0] weight_t;
   typedef weight_t filter_t [FILTER_N][FILTER_N];

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      WAIT_ACK,
      RELEASE
   } loader_state_e;

endpackage

// File: rtl/filter_fetch_ctr.sv
// Issue/capture counters and address generation for the filter loader.
// Ports: go/fetch control in; mem_rd_en/mem_addr out; capture strobe,
// row/col and last_capture out.
module filter_fetch_ctr #(
   parameter int N      = 5,
   parameter int ADDR_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   go,
   input  logic                   fetch,
   input  logic [ADDR_W-1:0]      base_addr,
   output logic                   mem_rd_en,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic                   cap_en,
   output logic [$clog2(N)-1:0]   cap_row,
   output logic [$clog2(N)-1:0]   cap_col,
   output logic                   last_capture
);

   localparam int NN = N * N;
   localparam int CW = $clog2(NN);
   localparam int RW = $clog2(N);

   logic [CW-1:0]     issue_cnt;
   logic              issuing;
   logic [ADDR_W-1:0] next_addr;
   logic              cap_pending;
   logic              issue_now;

   // Word 0 goes out in the same cycle start is accepted;
   // the rest follow from FETCH on consecutive cycles.
   assign issue_now = fetch & issuing;
   assign mem_rd_en = go | issue_now;

   always_comb begin
      mem_addr = '0;
      if (go) begin
         mem_addr = base_addr;
      end else if (issue_now) begin
         mem_addr = next_addr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_cnt <= '0;
         issuing   <= 1'b0;
         next_addr <= '0;
      end else if (go) begin
         issue_cnt <= CW'(1);
         issuing   <= 1'b1;
         next_addr <= base_addr + ADDR_W'(1);
      end else if (issue_now) begin
         next_addr <= next_addr + ADDR_W'(1);
         if (issue_cnt == CW'(NN - 1)) begin
            issuing   <= 1'b0;
            issue_cnt <= '0;
         end else begin
            issue_cnt <= issue_cnt + CW'(1);
         end
      end
   end

   // Read data is valid the cycle after its strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_pending <= 1'b0;
         cap_row     <= '0;
         cap_col     <= '0;
      end else begin
         cap_pending <= mem_rd_en;
         if (go) begin
            cap_row <= '0;
            cap_col <= '0;
         end else if (cap_pending) begin
            if (cap_col == RW'(N - 1)) begin
               cap_col <= '0;
               if (cap_row == RW'(N - 1)) begin
                  cap_row <= '0;
               end else begin
                  cap_row <= cap_row + RW'(1);
               end
            end else begin
               cap_col <= cap_col + RW'(1);
            end
         end
      end
   end

   assign cap_en       = cap_pending;
   assign last_capture = cap_pending
                         && (cap_row == RW'(N - 1))
                         && (cap_col == RW'(N - 1));

endmodule

// File: rtl/filter_loader.sv
// Loads an NxN signed weight filter from memory, row-major, and hands it
// to the filter buffer over read/finish. Ports: start/base_addr in,
// busy/done out, mem_rd_en/mem_addr/mem_rdata memory side,
// buf_read/buf_filter/buf_finish buffer side.
// FILTER_LOADER_CHECKSUM_EN adds a wrapping sum output `checksum`.
module filter_loader
   import cnn_pkg::*;
#(
   parameter int N      = FILTER_N,
   parameter int ADDR_W = WADDR_W,
   parameter int DATA_W = WEIGHT_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        base_addr,
   output logic                     busy,
   output logic                     done,
`ifdef FILTER_LOADER_CHECKSUM_EN
   output logic [DATA_W-1:0]        checksum,
`endif
   output logic                     mem_rd_en,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic                     buf_read,
   output logic signed [DATA_W-1:0] buf_filter [N][N],
   input  logic                     buf_finish
);

   loader_state_e state;
   loader_state_e state_nxt;

   logic                 go;
   logic                 done_nxt;
   logic                 cap_en;
   logic [$clog2(N)-1:0] cap_row;
   logic [$clog2(N)-1:0] cap_col;
   logic                 last_capture;

   // rst_n gate keeps the combinational first read quiet in reset.
   assign go = (state == IDLE) & start & rst_n;

   filter_fetch_ctr #(
      .N      (N),
      .ADDR_W (ADDR_W)
   ) u_ctr (
      .clk          (clk),
      .rst_n        (rst_n),
      .go           (go),
      .fetch        (state == FETCH),
      .base_addr    (base_addr),
      .mem_rd_en    (mem_rd_en),
      .mem_addr     (mem_addr),
      .cap_en       (cap_en),
      .cap_row      (cap_row),
      .cap_col      (cap_col),
      .last_capture (last_capture)
   );

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            if (last_capture) begin
               state_nxt = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (buf_finish) begin
               state_nxt = RELEASE;
            end
         end
         RELEASE: begin
            if (!buf_finish) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= done_nxt;
      end
   end

   assign busy     = (state != IDLE);
   assign buf_read = (state == WAIT_ACK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               buf_filter[r][c] <= '0;
            end
         end
      end else if (cap_en) begin
         buf_filter[cap_row][cap_col] <= mem_rdata;
      end
   end

`ifdef FILTER_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         checksum <= '0;
      end else if (go) begin
         checksum <= '0;
      end else if (cap_en) begin
         checksum <= checksum + mem_rdata;
      end
   end
`endif

endmodule

// File: tb/tb_filter_loader.sv
// Scoreboard bench for filter_loader: memory and buffer models,
// read/filter monitors fed by expectation queues.
module tb_filter_loader;

   localparam int N  = 5;
   localparam int NN = N * N;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                start;
   logic [15:0]         base_addr;
   logic                busy;
   logic                done;
   logic                mem_rd_en;
   logic [15:0]         mem_addr;
   logic [15:0]         mem_rdata = 16'h0;
   logic                buf_read;
   logic signed [15:0]  buf_filter [N][N];
   logic                buf_finish = 1'b0;
`ifdef FILTER_LOADER_CHECKSUM_EN
   logic [15:0]         checksum;
   logic [15:0]         exp_sum [$];
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int got;

   logic [15:0] exp_addr [$];
   logic [15:0] exp_word [$];

   logic [15:0] mem_base = 16'h0;
   int          mem_bias = 0;
   int          hold_cfg = 0;
   int          held     = 0;
   logic        prev_read = 1'b0;

   filter_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .busy       (busy),
      .done       (done),
`ifdef FILTER_LOADER_CHECKSUM_EN
      .checksum   (checksum),
`endif
      .mem_rd_en  (mem_rd_en),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .buf_read   (buf_read),
      .buf_filter (buf_filter),
      .buf_finish (buf_finish)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] word_at(input logic [15:0] a);
      logic [15:0] off;
      off = a - mem_base;
      return 16'(mem_bias + int'(off));
   endfunction

   // Memory: data one cycle after the strobe.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= word_at(mem_addr);
   end

   // Buffer: finish follows read after hold_cfg extra cycles.
   always @(posedge clk) begin
      buf_finish <= buf_read && (held >= hold_cfg);
      held <= buf_read ? held + 1 : 0;
   end

   // Read monitor.
   always @(negedge clk) begin
      if (mem_rd_en) begin
         if (exp_addr.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_read: got addr %0h want none", mem_addr);
         end else begin
            chk("read_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
         end
      end
   end

   // Filter monitor at the buf_read rise.
   always @(negedge clk) begin
      if (buf_read && !prev_read) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               if (exp_word.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL filter_unexpected: r%0d c%0d", r, c);
               end else begin
                  chk("filter", 32'($unsigned(buf_filter[r][c])),
                      32'(exp_word.pop_front()));
               end
            end
         end
`ifdef FILTER_LOADER_CHECKSUM_EN
         if (exp_sum.size() == 0) begin
            total++;
            bad++;
            $display("FAIL checksum_unexpected: got %0h", checksum);
         end else begin
            chk("checksum", 32'(checksum), 32'(exp_sum.pop_front()));
         end
`endif
      end
      prev_read = buf_read;
   end

   task automatic push_load(input logic [15:0] base, input int bias);
      int s;
      s = 0;
      for (int k = 0; k < NN; k++) begin
         exp_addr.push_back(base + 16'(k));
         exp_word.push_back(16'(bias + k));
         s += bias + k;
      end
`ifdef FILTER_LOADER_CHECKSUM_EN
      exp_sum.push_back(16'(s));
`endif
   endtask

   task automatic check_idle_outputs(input string tag);
      int nz;
      nz = 0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            if (buf_filter[r][c] != 0) nz++;
      chk({tag, "_rd_en"}, 32'(mem_rd_en), 0);
      chk({tag, "_addr"}, 32'(mem_addr), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_read"}, 32'(buf_read), 0);
      chk({tag, "_filter"}, 32'(nz), 0);
   endtask

   task automatic run_load(input logic [15:0] base, input int bias,
                           input int hold, input bit poke,
                           input bit from_reset, input int want_lat,
                           input string tag);
      logic [15:0] expw [NN];
      int e0;
      int ok;
      int rc;
      int viol;
      mem_base = base;
      mem_bias = bias;
      hold_cfg = hold;
      for (int k = 0; k < NN; k++) expw[k] = 16'(bias + k);
      push_load(base, bias);
      if (from_reset) begin
         @(posedge clk);
         #1 rst_n = 1'b1;
      end else begin
         @(posedge clk);
         #1 base_addr = base;
         start = 1'b1;
      end
      @(posedge clk);
      #1 start = 1'b0;
      e0 = cyc;
      @(negedge clk);
      chk({tag, "_busy_rise"}, 32'(busy), 1);
      ok = 0;
      rc = 0;
      viol = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1;
            break;
         end
         if (buf_read) begin
            rc++;
            for (int r = 0; r < N; r++)
               for (int c = 0; c < N; c++)
                  if ($unsigned(buf_filter[r][c]) != expw[r*N+c]) viol++;
         end
         start = poke && buf_read && (rc == 10);
      end
      start = 1'b0;
      if (ok == 1) begin
         chk({tag, "_done_lat"}, 32'(cyc - e0 + 1), 32'(want_lat));
         chk({tag, "_busy_fall"}, 32'(busy), 0);
      end else begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got no done want done", tag);
      end
      chk({tag, "_reads_left"}, 32'(exp_addr.size()), 0);
      chk({tag, "_stable"}, 32'(viol), 0);
      if (hold > 0) chk({tag, "_read_hold"}, 32'(rc >= hold), 1);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b1;
      base_addr = 16'h0040;
      mem_base  = 16'h0040;
      mem_bias  = 7;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_idle_outputs("rst");
      end
      run_load(16'h0040, 7, 0, 1'b0, 1'b1, 30, "rst_start");

      run_load(16'h0100, 1, 0, 1'b0, 1'b0, 30, "basic");
      run_load(16'hFFF0, 256, 0, 1'b0, 1'b0, 30, "wrap");
      run_load(16'h0400, 1000, 40, 1'b1, 1'b0, 70, "slow");

      mem_base = 16'h0500;
      mem_bias = 3;
      hold_cfg = 0;
      push_load(16'h0500, 3);
      @(posedge clk);
      #1 base_addr = 16'h0500;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      got = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         #1;
         if (exp_addr.size() <= NN - 11) begin
            got = 1;
            break;
         end
      end
      chk("midrst_reached", 32'(got), 1);
      rst_n = 1'b0;
      exp_addr.delete();
      exp_word.delete();
`ifdef FILTER_LOADER_CHECKSUM_EN
      exp_sum.delete();
`endif
      #1 check_idle_outputs("midrst");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midrst_hold_rd", 32'(mem_rd_en), 0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_load(16'h0200, 50, 0, 1'b0, 1'b0, 30, "after_rst");

      run_load(16'h0300, -100, 0, 1'b0, 1'b0, 30, "neg");

      repeat (3) @(negedge clk);
      chk("pending_filters", 32'(exp_word.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
